// File: rtl/gate_pkg.sv
// Shared constants and types for the 16-bit bus gate library.
package gate_pkg;

    localparam int unsigned GATE_WIDTH = 16;

    typedef logic [GATE_WIDTH-1:0] word_t;

endpackage

// File: rtl/and_1bit.sv
// Single-bit AND cell built as NAND followed by an inverter.
module and_1bit (
    input  logic a,
    input  logic b,
    output logic y
);

    logic nand_y;

    assign nand_y = ~(a & b);
    assign y      = ~nand_y;

endmodule

// File: rtl/and_16.sv
// 16-bit bitwise AND: combinational result from per-bit cells plus a one-cycle registered copy.
module and_16
    import gate_pkg::*;
#(
    parameter int unsigned WIDTH = GATE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and_1bit u_and (
            .a (a[i]),
            .b (b[i]),
            .y (out[i])
        );
    end

    // Reset clears only the registered copy; out stays live through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out;
        end
    end

endmodule

// File: tb/tb_and_16.sv
// Self-checking bench for and_16: directed edge cases plus randomized vectors against a reference model.
module tb_and_16;
    import gate_pkg::*;

    logic  clk;
    logic  rst;
    word_t a;
    word_t b;
    word_t out;
    word_t out_q;

    int unsigned tests_run;
    int unsigned tests_failed;
    word_t       exp_q;

    and_16 #(
        .WIDTH (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .out   (out),
        .out_q (out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each output bit is the product of the two operand bits.
    function automatic word_t ref_and(input word_t x, input word_t y);
        int unsigned acc;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            acc += (((x >> i) & 1) * ((y >> i) & 1)) << i;
        end
        return word_t'(acc);
    endfunction

    task automatic check(input string tag, input word_t got, input word_t exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge: drive, check comb output, clock once, check register.
    task automatic apply(input string tag, input word_t av, input word_t bv, input logic rv);
        a   = av;
        b   = bv;
        rst = rv;
        #1;
        check({tag, "_out"}, out, ref_and(av, bv));
        exp_q = rv ? '0 : ref_and(av, bv);
        @(posedge clk);
        #1;
        check({tag, "_out_q"}, out_q, exp_q);
        check({tag, "_out_hold"}, out, ref_and(av, bv));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_q        = '0;
        a            = 16'h1234;
        b            = 16'hFFFF;
        rst          = 1'b1;

        @(posedge clk);
        #1;
        check("reset_out_q", out_q, 16'h0000);
        check("reset_out", out, 16'h1234);

        apply("zero", 16'h0000, 16'h0000, 1'b0);
        apply("hi_bits", 16'b1110000000000000, 16'b1010000000000000, 1'b0);
        apply("lo_bits", 16'b0000000000001100, 16'b0000000000000100, 1'b0);
        apply("ones", 16'hFFFF, 16'hFFFF, 1'b0);
        apply("a_zero", 16'h0000, 16'hBEEF, 1'b0);
        apply("b_zero", 16'hCAFE, 16'h0000, 1'b0);

        for (int i = 0; i < 16; i++) begin
            apply($sformatf("walk%0d", i), word_t'(1 << i), 16'hFFFF, 1'b0);
        end

        // Load a value, then reset twice: pending value must be discarded, out unaffected.
        apply("pre_rst", 16'hA5A5, 16'hFFFF, 1'b0);
        apply("rst_hold0", 16'hFFFF, 16'hFFFF, 1'b1);
        apply("rst_hold1", 16'hFFFF, 16'hFFFF, 1'b1);
        apply("rst_release", 16'hFFFF, 16'hFFFF, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            apply("rand", word_t'($urandom), word_t'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
